// File: rtl/ddr_app_responder.sv
// Stand-in for the MIG user interface: accepts app_* commands, keeps write
// bursts in on-chip RAM and returns read data after a fixed latency.
module ddr_app_responder #(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 8,
  parameter int CALIB_CYCLES   = 64,
  parameter int RDY_PERIOD     = 16,
  parameter int RDY_STALL      = 0
) (
  input  logic                  ddr_ui_clk,
  input  logic                  ddr_log_rst,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  input  logic [DATA_WIDTH-1:0] app_wdf_data,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_rdy,
  output logic                  app_wdf_rdy,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  init_calib_complete,
  output logic [3:0]            err_flags,
  output logic [31:0]           wr_cmd_cnt,
  output logic [31:0]           rd_cmd_cnt
);

  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam int THR_W     = (RDY_PERIOD > 1) ? $clog2(RDY_PERIOD) : 1;
  localparam int RDY_OPEN  = RDY_PERIOD - RDY_STALL;
  localparam int WF_DEPTH  = 4;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef logic [DATA_WIDTH-1:0]     word_t;
  typedef logic [MEM_DEPTH_LOG2-1:0] mem_idx_t;

  logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
  logic             calib_q, calib_d;
  logic [THR_W-1:0] thr_cnt_q, thr_cnt_d;
  logic [1:0]       wf_wr_ptr_q, wf_wr_ptr_d;
  logic [1:0]       wf_rd_ptr_q, wf_rd_ptr_d;
  logic [2:0]       wf_cnt_q, wf_cnt_d;
  logic [3:0]       err_q, err_d;
  logic [31:0]      wr_cnt_q, wr_cnt_d;
  logic [31:0]      rd_cnt_q, rd_cnt_d;
  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;

  word_t wf_mem    [WF_DEPTH];
  word_t ram       [MEM_DEPTH];
  word_t rd_data_q [RD_LATENCY];

  logic     thr_open, wf_empty, wf_full;
  logic     cmd_acc, wr_acc, rd_acc, ill_acc, beat_acc;
  logic     wr_has_data, ram_we, bypass, wf_push, wf_pop;
  word_t    wr_data;
  mem_idx_t mem_idx;
  logic     addr_hi_unused;

  // Upper address bits select nothing: the address space wraps onto the RAM.
  assign mem_idx        = app_addr[MEM_DEPTH_LOG2+2:3];
  assign addr_hi_unused = ^app_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3];

  // The read path is a plain shift register that advances every cycle, so it
  // can never fill and never needs to hold off app_rdy.
  assign thr_open    = int'(thr_cnt_q) < RDY_OPEN;
  assign app_rdy     = calib_q && thr_open;
  assign wf_empty    = (wf_cnt_q == 3'd0);
  assign wf_full     = (wf_cnt_q == 3'(WF_DEPTH));
  assign app_wdf_rdy = calib_q && !wf_full;

  assign cmd_acc  = app_en && app_rdy;
  assign wr_acc   = cmd_acc && (app_cmd == CMD_WRITE);
  assign rd_acc   = cmd_acc && (app_cmd == CMD_READ);
  assign ill_acc  = cmd_acc && (app_cmd[2:1] != 2'b00);
  assign beat_acc = app_wdf_wren && app_wdf_rdy;

  // A beat arriving with its command goes straight to RAM when nothing older
  // is queued; otherwise the FIFO head is consumed and the new beat queued.
  assign wr_has_data = !wf_empty || beat_acc;
  assign ram_we      = wr_acc && wr_has_data;
  assign bypass      = wr_acc && wf_empty && beat_acc;
  assign wf_push     = beat_acc && !bypass;
  assign wf_pop      = wr_acc && !wf_empty;
  assign wr_data     = wf_empty ? app_wdf_data : wf_mem[wf_rd_ptr_q];

  // NOTE: every _d signal takes its hold value first, so no path through
  // this block can leave a latch behind.
  always_comb begin
    cal_cnt_d   = cal_cnt_q;
    calib_d     = calib_q;
    thr_cnt_d   = (thr_cnt_q == THR_W'(RDY_PERIOD - 1)) ? '0 : thr_cnt_q + THR_W'(1);
    wf_wr_ptr_d = wf_push ? wf_wr_ptr_q + 2'd1 : wf_wr_ptr_q;
    wf_rd_ptr_d = wf_pop  ? wf_rd_ptr_q + 2'd1 : wf_rd_ptr_q;
    wf_cnt_d    = wf_cnt_q;
    wr_cnt_d    = wr_acc ? wr_cnt_q + 32'd1 : wr_cnt_q;
    rd_cnt_d    = rd_acc ? rd_cnt_q + 32'd1 : rd_cnt_q;
    rd_vld_d    = {rd_vld_q[RD_LATENCY-2:0], rd_acc};
    err_d       = err_q | {app_wdf_wren != app_wdf_end,
                           wr_acc && !wr_has_data,
                           cmd_acc && (app_addr[2:0] != 3'b000),
                           ill_acc};
    if (!calib_q) begin
      cal_cnt_d = cal_cnt_q + CAL_W'(1);
      if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_d = 1'b1;
    end
    case ({wf_push, wf_pop})
      2'b10:   wf_cnt_d = wf_cnt_q + 3'd1;
      2'b01:   wf_cnt_d = wf_cnt_q - 3'd1;
      default: wf_cnt_d = wf_cnt_q;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
    if (ddr_log_rst) begin
      cal_cnt_q   <= '0;
      calib_q     <= 1'b0;
      thr_cnt_q   <= '0;
      wf_wr_ptr_q <= '0;
      wf_rd_ptr_q <= '0;
      wf_cnt_q    <= '0;
      err_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= '0;
    end else begin
      cal_cnt_q   <= cal_cnt_d;
      calib_q     <= calib_d;
      thr_cnt_q   <= thr_cnt_d;
      wf_wr_ptr_q <= wf_wr_ptr_d;
      wf_rd_ptr_q <= wf_rd_ptr_d;
      wf_cnt_q    <= wf_cnt_d;
      err_q       <= err_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  // NOTE: storage arrays carry no reset so they map onto block RAM; only the
  // pointers and valid bits that qualify their contents are cleared.
  always_ff @(posedge ddr_ui_clk) begin
    if (wf_push) wf_mem[wf_wr_ptr_q] <= app_wdf_data;
  end

  // Registered read at acceptance: one command per cycle, so a write in the
  // previous cycle is already in the array when the read samples it.
  always_ff @(posedge ddr_ui_clk) begin
    if (ram_we) ram[mem_idx] <= wr_data;
    rd_data_q[0] <= ram[mem_idx];
  end

  always_ff @(posedge ddr_ui_clk) begin
    for (int i = 1; i < RD_LATENCY; i++) rd_data_q[i] <= rd_data_q[i-1];
  end

  assign app_rd_data_valid   = rd_vld_q[RD_LATENCY-1];
  assign app_rd_data         = rd_vld_q[RD_LATENCY-1] ? rd_data_q[RD_LATENCY-1] : '0;
  assign init_calib_complete = calib_q;
  assign err_flags           = err_q;
  assign wr_cmd_cnt          = wr_cnt_q;
  assign rd_cmd_cnt          = rd_cnt_q;

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed bench for ddr_app_responder: calibration, write/read bursts,
// throttling, hazards, aliasing, error flags and reset with reads in flight.
module tb_ddr_app_responder;

  localparam int AW  = 30;
  localparam int DW  = 512;
  localparam int MDL = 10;
  localparam int RDL = 8;
  localparam int CAL = 64;
  localparam int RP  = 16;
  localparam int RS  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          init_calib_complete;
  logic [3:0]    err_flags;
  logic [31:0]   wr_cmd_cnt;
  logic [31:0]   rd_cmd_cnt;

  ddr_app_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(MDL), .RD_LATENCY(RDL),
    .CALIB_CYCLES(CAL), .RDY_PERIOD(RP), .RDY_STALL(RS)
  ) dut (
    .ddr_ui_clk(clk), .ddr_log_rst(rst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .init_calib_complete(init_calib_complete), .err_flags(err_flags),
    .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_valid = 0;
  int          exp_wr = 0;
  int          exp_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Read-response scoreboard: in-order data and exact latency per accept.
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", DW'(app_rd_data_valid), '0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check("rd_data", app_rd_data, e.data);
        check("rd_latency", DW'(cyc - e.cyc), DW'(RDL));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
    end
  endtask

  task automatic do_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr, input bit with_beat,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd_exp,
                        output int unsigned acc_cyc);
    bit      cmd_done;
    bit      beat_done;
    int      guard;
    rd_exp_t e;
    cmd_done  = 1'b0;
    beat_done = !with_beat;
    guard     = 0;
    acc_cyc   = 0;
    while (!(cmd_done && beat_done) && guard < 64) begin
      @(negedge clk);
      app_en       = !cmd_done;
      app_cmd      = cmd;
      app_addr     = addr;
      app_wdf_wren = !beat_done;
      app_wdf_end  = !beat_done;
      app_wdf_data = wd;
      if (!beat_done && app_wdf_rdy) beat_done = 1'b1;
      if (!cmd_done && app_rdy) begin
        cmd_done = 1'b1;
        acc_cyc  = cyc;
        if (cmd == 3'b000) exp_wr++;
        if (cmd == 3'b001) begin
          exp_rd++;
          e.cyc  = acc_cyc;
          e.data = rd_exp;
          exp_q.push_back(e);
        end
      end
      guard++;
    end
    check("cmd_handshake", DW'({cmd_done, beat_done}), DW'(2'b11));
  endtask

  task automatic calib_check();
    for (int k = 1; k <= CAL; k++) begin
      @(negedge clk);
      if (k < CAL) check("rdy_before_calib", DW'({init_calib_complete, app_rdy, app_wdf_rdy}), '0);
      else         check("calib_at_64", DW'({init_calib_complete, app_rdy, app_wdf_rdy}), DW'(3'b111));
    end
  endtask

  // Returns on the first cycle of a 12-cycle app_rdy-high window.
  task automatic wait_window();
    int g;
    g = 0;
    do begin @(negedge clk); g++; end while (app_rdy && g < 40);
    while (!app_rdy && g < 40) begin @(negedge clk); g++; end
    check("window_found", DW'(g < 40), DW'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a, w_cyc, r_cyc;
    int          base, lows, accs, g;
    rd_exp_t     e;
    logic [DW-1:0] h1, h2, h3;
    h1 = DW'(64'hDEAD_0040_0000_0001);
    h2 = DW'(64'hBEEF_2040_0000_0002);
    h3 = DW'(64'h5A5A_0080_0000_0003);

    app_addr = '0; app_cmd = '0; app_en = 1'b0;
    app_wdf_data = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;

    // Reset state
    idle(3);
    check("rst_outputs", DW'({app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete, err_flags}), '0);
    check("rst_rd_data", app_rd_data, '0);
    check("rst_counts", DW'({wr_cmd_cnt, rd_cmd_cnt}), '0);
    rst = 1'b0;
    calib_check();
    check("err_after_calib", DW'(err_flags), '0);

    // 128 writes, data = index, beat with command
    for (int i = 0; i < 128; i++) do_cmd(3'b000, AW'(i * 8), 1'b1, DW'(i), '0, a);
    idle(1);
    check("wr_cnt_128", DW'(wr_cmd_cnt), DW'(128));

    // 128 reads back in order
    base = n_valid;
    for (int i = 0; i < 128; i++) do_cmd(3'b001, AW'(i * 8), 1'b0, '0, DW'(i), a);
    idle(14);
    check("rd_cnt_128", DW'(rd_cmd_cnt), DW'(128));
    check("valids_128", DW'(n_valid - base), DW'(128));
    check("queue_drained_b", DW'(exp_q.size()), '0);

    // Continuous read requests under throttle: 4 of 16 cycles stalled
    base = n_valid; lows = 0; accs = 0;
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      app_en = 1'b1; app_cmd = 3'b001; app_addr = AW'(accs * 8);
      if (app_rdy) begin
        e.cyc = cyc; e.data = DW'(accs); exp_q.push_back(e);
        accs++; exp_rd++;
      end else begin
        lows++;
      end
    end
    idle(14);
    check("throttle_lows", DW'(lows), DW'(8));
    check("throttle_accepts", DW'(accs), DW'(24));
    check("throttle_valids", DW'(n_valid - base), DW'(24));
    check("rd_cnt_152", DW'(rd_cmd_cnt), DW'(152));

    // Read-after-write hazard and address aliasing
    wait_window();
    do_cmd(3'b000, AW'('h40), 1'b1, h1, '0, w_cyc);
    do_cmd(3'b001, AW'('h40), 1'b0, '0, h1, r_cyc);
    check("raw_back_to_back", DW'(r_cyc - w_cyc), DW'(1));
    do_cmd(3'b000, AW'((1 << (MDL + 3)) + 'h40), 1'b1, h2, '0, a);
    do_cmd(3'b001, AW'('h40), 1'b0, '0, h2, a);
    idle(14);
    check("queue_drained_d", DW'(exp_q.size()), '0);
    check("counts_d", DW'({wr_cmd_cnt, rd_cmd_cnt}), DW'({32'd130, 32'd154}));
    check("err_clean", DW'(err_flags), '0);

    // Error flags
    do_cmd(3'b111, AW'(0), 1'b0, '0, '0, a);
    idle(1);
    check("err_illegal", DW'(err_flags), DW'(4'b0001));
    check("illegal_not_counted", DW'({wr_cmd_cnt, rd_cmd_cnt}), DW'({32'd130, 32'd154}));
    do_cmd(3'b000, AW'('h100), 1'b0, '0, '0, a);
    idle(1);
    check("err_no_data", DW'(err_flags), DW'(4'b0101));
    check("nodata_counted", DW'(wr_cmd_cnt), DW'(131));
    do_cmd(3'b001, AW'('h4), 1'b0, '0, DW'(0), a);
    idle(1);
    check("err_misaligned", DW'(err_flags), DW'(4'b0111));
    @(negedge clk);
    app_wdf_wren = 1'b1; app_wdf_end = 1'b0; app_wdf_data = h3;
    check("beat_rdy", DW'(app_wdf_rdy), DW'(1));
    idle(1);
    check("err_wren_end", DW'(err_flags), DW'(4'b1111));
    idle(4);
    check("err_sticky", DW'(err_flags), DW'(4'b1111));
    do_cmd(3'b000, AW'('h80), 1'b0, '0, '0, a);
    do_cmd(3'b001, AW'('h80), 1'b0, '0, h3, a);
    idle(14);
    check("queue_drained_e", DW'(exp_q.size()), '0);
    check("counts_e", DW'({wr_cmd_cnt, rd_cmd_cnt}), DW'({32'd132, 32'd156}));

    // Reset with 5 reads in flight
    wait_window();
    for (int i = 1; i <= 5; i++) do_cmd(3'b001, AW'(i * 8), 1'b0, '0, DW'(i), a);
    idle(1);
    g = 0;
    while (!app_rd_data_valid && g < 20) begin @(negedge clk); g++; end
    check("inflight_valid_seen", DW'(app_rd_data_valid), DW'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_valid_drop", DW'(app_rd_data_valid), '0);
    check("rst_rd_data_zero", app_rd_data, '0);
    check("rst_state", DW'({app_rdy, app_wdf_rdy, init_calib_complete, err_flags, wr_cmd_cnt, rd_cmd_cnt}), '0);
    exp_q.delete();
    base = n_valid;
    idle(4);
    rst = 1'b0;
    calib_check();
    check("no_valid_after_rst", DW'(n_valid - base), '0);
    do_cmd(3'b001, AW'(16), 1'b0, '0, DW'(2), a);
    do_cmd(3'b001, AW'('h80), 1'b0, '0, h3, a);
    idle(14);
    check("queue_drained_f", DW'(exp_q.size()), '0);
    check("post_rst_counts", DW'({wr_cmd_cnt, rd_cmd_cnt}), DW'({32'd0, 32'd2}));
    check("post_rst_err", DW'(err_flags), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_app_responder.md
Name: ddr_app_responder

Overview:
- Synthesizable responder for the MIG user (app) interface. It emulates the controller side that the DDR write/read FSM drives: it accepts app_* commands, stores write bursts in on-chip RAM, and returns read data with a fixed latency.
- Used in bring-up builds and in simulation in place of the MIG core, so the DDR buffering path can be exercised without a memory part.
- Adds calibration delay, programmable app_rdy back-pressure, protocol-violation flags and command counters.

Parameters:
ADDR_WIDTH, 30, width of app_addr
DATA_WIDTH, 512, width of app_wdf_data / app_rd_data
MEM_DEPTH_LOG2, 10, log2 of the number of 512-bit burst locations in the backing RAM
RD_LATENCY, 8, cycles from read-command acceptance to app_rd_data_valid (minimum 2)
CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises
RDY_PERIOD, 16, period of the app_rdy throttle counter
RDY_STALL, 0, cycles per period with app_rdy forced low (0 = never throttled; must be < RDY_PERIOD)

Ports:
ddr_ui_clk  in  1  single clock for the whole block
ddr_log_rst  in  1  asynchronous active-high reset
app_addr  in  ADDR_WIDTH  command address (burst address step 8)
app_cmd  in  3  000 = write, 001 = read, any other value is illegal
app_en  in  1  command valid
app_wdf_data  in  DATA_WIDTH  write data
app_wdf_wren  in  1  write data valid
app_wdf_end  in  1  last beat of write burst (must equal app_wdf_wren)
app_rdy  out  1  command accepted when app_en && app_rdy
app_wdf_rdy  out  1  write data accepted when app_wdf_wren && app_wdf_rdy
app_rd_data  out  DATA_WIDTH  read data
app_rd_data_valid  out  1  read data strobe
init_calib_complete  out  1  calibration done (sticky)
err_flags  out  4  sticky: [0] illegal cmd, [1] misaligned addr, [2] write cmd with no data, [3] wdf_end != wdf_wren
wr_cmd_cnt  out  32  accepted write commands, wraps
rd_cmd_cnt  out  32  accepted read commands, wraps

Behaviour:
- Reset: all outputs 0; calibration counter, throttle counter, write-data FIFO and read pipeline are cleared. RAM contents are not reset.
- Reset asserted mid-operation: in-flight reads are discarded and app_rd_data_valid drops immediately.
- Calibration:
  - A counter runs from reset release; init_calib_complete goes 1 on cycle CALIB_CYCLES and stays 1 until the next reset.
  - Before calibration completes, app_rdy = app_wdf_rdy = 0.
- Throttle:
  - A free-running counter counts 0..RDY_PERIOD-1.
  - app_rdy = calib && (cnt < RDY_PERIOD-RDY_STALL) && read pipeline not full.
- Write-data FIFO:
  - Depth 4; app_wdf_rdy = calib && FIFO not full.
  - Data beats may arrive before or in the same cycle as their command.
  - A same-cycle beat bypasses the FIFO when the FIFO is empty.
- Write command accepted:
  - The FIFO head (or the bypass beat) is written to RAM[app_addr[MEM_DEPTH_LOG2+2:3]] in the same cycle, and wr_cmd_cnt increments.
  - If no data is available, set err_flags[2], drop the command, and still count it.
- Read command accepted:
  - The RAM index enters a RD_LATENCY-deep shift pipeline (one RAM read stage included).
  - app_rd_data_valid pulses exactly RD_LATENCY cycles after acceptance; responses are in order and back-to-back reads give back-to-back valids. rd_cmd_cnt increments.
- Hazard: a read accepted on the cycle after a write to the same index returns the new data (RAM is write-first or bypassed).
- Addressing:
  - Address bits above MEM_DEPTH_LOG2+2 are ignored, so the address space wraps modulo the depth.
  - app_addr[2:0] != 0 sets err_flags[1]; the access still uses the aligned index.
- Illegal app_cmd with app_en && app_rdy: set err_flags[0]; no RAM access; neither counter changes.
- app_wdf_wren != app_wdf_end in any cycle: set err_flags[3]; the beat is still accepted when wren is high.
- Only one command per cycle. Reads and writes are accepted in any interleaving; there is no reordering.
- Counters wrap 0xFFFFFFFF -> 0 with no flag.

Test Plan:
- Reset, CALIB_CYCLES=64 -> init_calib_complete rises on cycle 64 after release; app_rdy/app_wdf_rdy are 0 before it; err_flags=0.
- 128 writes, addr 0,8,...,1016, data = index, wdf with cmd; then 128 reads of the same addresses -> 128 valids, each RD_LATENCY=8 cycles after its accept, data 0..127 in order; wr_cmd_cnt = rd_cmd_cnt = 128.
- RDY_PERIOD=16, RDY_STALL=4, continuous read requests -> app_rdy low 4 of every 16 cycles; no command is lost or duplicated; the valid count equals the accept count.
- Write to addr 0x40 at cycle N, read 0x40 at cycle N+1 -> returned data equals the new value. Write to addr (1<<(MEM_DEPTH_LOG2+3)) + 0x40 -> aliases onto 0x40.
- app_cmd=3'b111, write cmd with empty FIFO and no wren, addr 0x4, wren=1 with end=0 -> err_flags = 4'b1111 and sticky; illegal cmd not counted.
- Reset asserted with 5 reads in flight -> app_rd_data_valid 0 the same cycle; after re-calibration, reading earlier-written data returns the pre-reset RAM contents.
